// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the stage-register occupancy state and its maximum depth.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int unsigned PIPE_DEPTH_MAX = 2;

  function automatic logic [1:0] state_occupancy(input pipe_state_t st);
    case (st)
      EMPTY:   state_occupancy = 2'd0;
      ONE:     state_occupancy = 2'd1;
      TWO:     state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush and reset.
// PIPE_STAGE_SKID_EN adds a skid entry so that in_ready is fully registered.
module pipeline_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_r;
  pipe_state_t      state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic             out_valid_r;
  logic [1:0]       occupancy_r;
  logic             accept_s;
  logic             pop_s;

  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid_r && out_ready;
  assign out_valid = out_valid_r;
  assign occupancy = occupancy_r;
  assign out_data  = main_r;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_ready_r;

  // Registered ready; reset still blocks upstream immediately.
  assign in_ready = in_ready_r && !RST;

  // Next-state and payload selection for the two-entry stage.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = FLUSH_VAL;
      skid_nxt_s  = FLUSH_VAL;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            main_nxt_s = in_data;
          end else if (accept_s) begin
            state_nxt_s = TWO;
            skid_nxt_s  = in_data;
          end else if (pop_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = FLUSH_VAL;
          skid_nxt_s  = FLUSH_VAL;
        end
      endcase
    end
  end

  // Skid payload and registered ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      skid_r     <= FLUSH_VAL;
      in_ready_r <= 1'b1;
    end else begin
      skid_r     <= skid_nxt_s;
      in_ready_r <= (state_nxt_s != TWO);
    end
  end
`else
  assign in_ready = (!out_valid_r || out_ready) && !RST;

  // Next-state and payload selection for the single-entry stage.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = FLUSH_VAL;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s) begin
            main_nxt_s = in_data;
          end else if (pop_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = FLUSH_VAL;
        end
      endcase
    end
  end
`endif

  // State, main payload and the status outputs derived from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= EMPTY;
      main_r      <= FLUSH_VAL;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      out_valid_r <= (state_nxt_s != EMPTY);
      occupancy_r <= state_occupancy(state_nxt_s);
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: directed table, corner sequences, random vs queue model.
module tb_pipeline_stage_reg;
  import cpu_types_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? PIPE_DEPTH_MAX : 1;
  localparam logic [31:0] FV = 32'hDEAD_BEEF;

  logic        CLK;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [31:0] hold_v;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_occ;
    logic        e_rdy;
  } vec_t;
  vec_t tbl[10];

  pipeline_stage_reg #(.WIDTH(32), .FLUSH_VAL(FV)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the queue model, clock, update the model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic rs);
    logic        exp_rdy;
    logic        acc;
    logic        pp;
    logic [31:0] exp_data;
    in_valid = v; in_data = d; out_ready = r; flush = f; RST = rs;
    #1;
    if (rs) exp_rdy = 1'b0;
    else if (SKID) exp_rdy = (q.size() < CAP);
    else exp_rdy = (q.size() == 0) || r;
    exp_data = (q.size() != 0) ? q[0] : hold_v;
    chk("model in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("model out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("model occupancy", {30'd0, occupancy}, 32'(q.size()));
    chk("model out_data", out_data, exp_data);
    acc = v && exp_rdy;
    pp  = (q.size() != 0) && r;
    @(posedge CLK);
    if (rs || f) begin
      q.delete();
      hold_v = FV;
    end else begin
      if (pp) hold_v = q.pop_front();
      if (acc) q.push_back(d);
    end
    @(negedge CLK);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k] = '{v: 1'b1, d: 32'(k + 1), r: 1'b1, e_valid: (k > 0),
                 e_data: (k > 0) ? 32'(k) : FV, e_occ: (k > 0) ? 2'd1 : 2'd0, e_rdy: 1'b1};
    end
    tbl[8] = '{v: 1'b0, d: 32'd0, r: 1'b1, e_valid: 1'b1, e_data: 32'd8, e_occ: 2'd1, e_rdy: 1'b1};
    tbl[9] = '{v: 1'b0, d: 32'd0, r: 1'b1, e_valid: 1'b0, e_data: 32'd8, e_occ: 2'd0, e_rdy: 1'b1};

    // Reset held for two cycles.
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; flush = 1'b0; RST = 1'b1;
    #1;
    chk("in_ready during reset", {31'd0, in_ready}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset occupancy", {30'd0, occupancy}, 32'd0);
    chk("reset out_data", out_data, FV);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    hold_v = FV;

    // Streaming table.
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; out_ready = tbl[i].r; flush = 1'b0; RST = 1'b0;
      #1;
      chk("stream out_valid", {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
      chk("stream out_data", out_data, tbl[i].e_data);
      chk("stream occupancy", {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
      chk("stream in_ready", {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, 1'b0);
    end

    // Backpressure.
    if (SKID) begin
      cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      chk("bp occupancy", {30'd0, occupancy}, 32'd2);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp out_data", out_data, 32'hA);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("bp second out_data", out_data, 32'hB);
      chk("bp in_ready after pop", {31'd0, in_ready}, 32'd1);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end else begin
      cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      chk("noskid in_ready stalled", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; in_valid = 1'b0;
      #1;
      chk("noskid in_ready same cycle", {31'd0, in_ready}, 32'd1);
      cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    end

    // Flush with a simultaneous offer that must be discarded.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    if (SKID) cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
    chk("flush occupancy", {30'd0, occupancy}, 32'd0);
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush out_data", out_data, FV);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Accept and pop in the same cycle.
    cycle(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h6, 1'b1, 1'b0, 1'b0);
    chk("simul out_data", out_data, 32'h6);
    chk("simul occupancy", {30'd0, occupancy}, 32'd1);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (legal range 1..256).
REQ-002 Parameter FLUSH_VAL, default '0, value loaded into all payload registers on flush and reset.
REQ-003 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-high.
REQ-005 Port flush  input  1  discard all held entries at the next edge.
REQ-006 Port in_valid  input  1  upstream offers in_data.
REQ-007 Port in_ready  output  1  stage accepts in_data this cycle.
REQ-008 Port in_data  input  WIDTH  upstream payload (a packed pipeline-bundle struct cast to bits).
REQ-009 Port out_valid  output  1  out_data holds a valid entry.
REQ-010 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 Port out_data  output  WIDTH  oldest held entry.
REQ-012 Port occupancy  output  2  number of held entries (0..2).

Function
REQ-013 Accept = in_valid && in_ready; pop = out_valid && out_ready; both evaluated in the same cycle.
REQ-014 Storage: main register (drives out_data) and skid register; state enum EMPTY, ONE, TWO.
REQ-015 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-016 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO, with no combinational path from out_ready.
REQ-017 EMPTY + accept -> ONE, main <= in_data; otherwise EMPTY is held.
REQ-018 ONE + accept, no pop -> TWO, skid <= in_data.
REQ-019 ONE + pop, no accept -> EMPTY.
REQ-020 ONE + accept + pop -> ONE, main <= in_data.
REQ-021 ONE with neither event -> ONE, registers held.
REQ-022 TWO + pop -> ONE, main <= skid; TWO without pop SHALL hold both registers unchanged.
REQ-023 Latency SHALL be one cycle, in_data accepted at edge N appearing on out_data after edge N when the stage is empty; sustained throughput SHALL be one entry per cycle while out_ready=1.
REQ-024 Ordering SHALL be strict FIFO; entries are never dropped or duplicated except by flush or reset.
REQ-025 flush=1 -> next state EMPTY, main and skid <= FLUSH_VAL, and in_ready 1 after the edge.
REQ-026 flush overrides any simultaneous accept or pop; a pop coinciding with flush still counts as consumed by downstream.
REQ-027 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 RST=1 at an edge -> state EMPTY, main and skid = FLUSH_VAL, out_valid 0, occupancy 0, in_ready 1 after the edge.
REQ-029 in_ready SHALL be forced to 0 combinationally while RST=1.
REQ-030 RST SHALL take priority over flush, accept and pop; reset mid-transfer discards all held entries.

Configuration
REQ-031 Macro PIPE_STAGE_SKID_EN defined: behaviour per REQ-014..REQ-027, with registered in_ready and depth 2.
REQ-032 PIPE_STAGE_SKID_EN undefined: no skid register and states EMPTY/ONE only, in_ready = !out_valid || out_ready (combinational), occupancy 0..1, full throughput retained, and flush/reset rules unchanged.

Structure
REQ-033 State enum pipe_state_t (EMPTY, ONE, TWO) and constant PIPE_DEPTH_MAX=2 SHALL reside in the shared cpu_types_pkg.
REQ-034 Single module with no sub-module; pipeline bundles (IF/ID, ID/EX, EX/MEM, MEM/WB) SHALL instantiate it with WIDTH set to $bits of their struct.

Verification
REQ-035 Reset: RST=1 for 2 cycles, then RST=0 -> out_valid=0, occupancy=0, out_data=FLUSH_VAL, in_ready=1.
REQ-036 Streaming: WIDTH=32, push 0x1..0x8 on consecutive cycles with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, one cycle later, occupancy stays 1.
REQ-037 Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB, in_ready=1 a cycle after the first pop.
REQ-038 Flush: hold 0xA, 0xB, assert flush together with in_valid (0xC) -> next cycle occupancy=0, out_valid=0, and 0xC never appears.
REQ-039 Simultaneous: state ONE (0x5), accept 0x6 and pop together -> out_data=0x6, occupancy=1.
REQ-040 Skid disabled: build without PIPE_STAGE_SKID_EN, out_ready=0 with one held entry -> in_ready=0; out_ready=1 -> in_ready=1 in the same cycle.
